// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller: state encoding and the
// counter-width helper used to size the phase/timeout counter.
package sar_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SAMPLE  = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] COMPARE = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    // Width of the shared phase counter: wide enough to hold the largest
    // cycle parameter, plus one bit of headroom.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Capture stage for the comparator's differential decision.
// Default: one register stage. With SAR_CMP_SYNC_EN defined: a two-flop
// synchronizer. A decision is valid only when Outp and Outn differ; both
// high (precharge) or both low carries no information.
module sar_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_outp,
    input  logic cmp_outn,
    output logic cmp_valid,
    output logic cmp_bit
);

    logic outp_r;
    logic outn_r;

`ifdef SAR_CMP_SYNC_EN
    logic meta_p_r;
    logic meta_n_r;

    // Two-flop synchronizer on both comparator rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p_r <= 1'b0;
            meta_n_r <= 1'b0;
            outp_r   <= 1'b0;
            outn_r   <= 1'b0;
        end else begin
            meta_p_r <= cmp_outp;
            meta_n_r <= cmp_outn;
            outp_r   <= meta_p_r;
            outn_r   <= meta_n_r;
        end
    end
`else
    // Single register stage on both comparator rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outp_r <= 1'b0;
            outn_r <= 1'b0;
        end else begin
            outp_r <= cmp_outp;
            outn_r <= cmp_outn;
        end
    end
`endif

    assign cmp_valid = outp_r ^ outn_r;
    assign cmp_bit   = outp_r;

endmodule

// File: rtl/sar_logic.sv
// SAR conversion controller: sample, then per bit settle the CDAC, clock
// the comparator, take its decision (or force 0 on timeout) and precharge.
// All outputs are registered from the next-state values so that they line
// up exactly with the state they describe.
// Optional build macro: SAR_CMP_SYNC_EN (two-flop comparator synchronizer).
module sar_logic
    import sar_pkg::*;
#(
    parameter int NBITS          = 8,
    parameter int SAMPLE_CYCLES  = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_outp,
    input  logic             cmp_outn,
    output logic             cmp_clk,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] data,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [2:0]       state_r,  state_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [IDX_W-1:0] idx_r,    idx_nxt_s;
    logic [NBITS-1:0] code_r,   code_nxt_s;
    logic             err_r,    err_nxt_s;
    logic             cmp_valid_s;
    logic             cmp_bit_s;

    logic             cmp_clk_r;
    logic             sample_r;
    logic [NBITS-1:0] dac_r;
    logic [NBITS-1:0] data_r;
    logic             done_r;
    logic             busy_r;

    sar_cmp_sync u_cmp_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_outp  (cmp_outp),
        .cmp_outn  (cmp_outn),
        .cmp_valid (cmp_valid_s),
        .cmp_bit   (cmp_bit_s)
    );

    // Next-state, phase counter, bit index and trial-code computation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        code_nxt_s  = code_r;
        err_nxt_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SAMPLE;
                    cnt_nxt_s   = CNT_W'(1);
                    idx_nxt_s   = IDX_W'(NBITS - 1);
                    code_nxt_s  = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SAMPLE: begin
                if (cnt_r == CNT_W'(SAMPLE_CYCLES)) begin
                    state_nxt_s        = SETTLE;
                    cnt_nxt_s          = CNT_W'(1);
                    code_nxt_s         = '0;
                    code_nxt_s[idx_r]  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_r == CNT_W'(SETTLE_CYCLES)) begin
                    state_nxt_s = COMPARE;
                    cnt_nxt_s   = CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            COMPARE: begin
                // A real decision wins even on the last allowed cycle.
                if (cmp_valid_s) begin
                    code_nxt_s[idx_r] = cmp_bit_s;
                    state_nxt_s       = RECOVER;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
                    code_nxt_s[idx_r] = 1'b0;
                    err_nxt_s         = 1'b1;
                    state_nxt_s       = RECOVER;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (idx_r == IDX_W'(0)) begin
                    state_nxt_s = DONE;
                end else begin
                    idx_nxt_s             = idx_r - IDX_W'(1);
                    code_nxt_s[idx_nxt_s] = 1'b1;
                    cnt_nxt_s             = CNT_W'(1);
                    state_nxt_s           = SETTLE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                // Unreachable encodings fall back to a safe idle.
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
                code_nxt_s  = '0;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            idx_r     <= '0;
            code_r    <= '0;
            err_r     <= 1'b0;
            cmp_clk_r <= 1'b0;
            sample_r  <= 1'b0;
            dac_r     <= '0;
            data_r    <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            code_r    <= code_nxt_s;
            err_r     <= err_nxt_s;
            cmp_clk_r <= (state_nxt_s == COMPARE);
            sample_r  <= (state_nxt_s == SAMPLE);
            done_r    <= (state_nxt_s == DONE);
            busy_r    <= (state_nxt_s != IDLE);
            if (state_nxt_s inside {SETTLE, COMPARE, RECOVER, DONE}) begin
                dac_r <= code_nxt_s;
            end else begin
                dac_r <= '0;
            end
            if (state_nxt_s == DONE) begin
                data_r <= code_nxt_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign cmp_clk  = cmp_clk_r;
    assign sample   = sample_r;
    assign dac_code = dac_r;
    assign data     = data_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic with an ideal comparator model.
module tb_sar_logic;

`ifdef SAR_CMP_SYNC_EN
    localparam int CMP_LEN = 3;
`else
    localparam int CMP_LEN = 2;
`endif
    localparam int LAT         = 4 + 8 * (2 + CMP_LEN + 1);
    localparam int STUCK_EXTRA = 8 - CMP_LEN;
    localparam int PERIOD      = LAT + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cmp_outp;
    logic       cmp_outn;
    logic       cmp_clk;
    logic       sample;
    logic [7:0] dac_code;
    logic [7:0] data;
    logic       done;
    logic       busy;
    logic       err;

    logic [7:0] code_in_v = 8'h00;
    logic       stuck_en  = 1'b0;
    int         edge_cnt  = 0;
    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] code_in;
        bit         stuck;
        bit         glitch;
        bit         trials;
        logic [7:0] exp_data;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    vec_t tbl[5];

    sar_logic dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmp_outp (cmp_outp),
        .cmp_outn (cmp_outn),
        .cmp_clk  (cmp_clk),
        .sample   (sample),
        .dac_code (dac_code),
        .data     (data),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Ideal comparator; optionally never resolves while bit 5 is on trial.
    always_comb begin
        if (!cmp_clk) begin
            cmp_outp = 1'b1;
            cmp_outn = 1'b1;
        end else if (stuck_en && dac_code[5] && (dac_code[4:0] == 5'd0)) begin
            cmp_outp = 1'b1;
            cmp_outn = 1'b1;
        end else begin
            cmp_outp = (code_in_v >= dac_code);
            cmp_outn = ~cmp_outp;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_conv(input vec_t v);
        int         s;
        int         n_samp;
        bit         busy_ok;
        bit         seen;
        logic       prev_cc;
        logic [7:0] exp_d;
        logic [7:0] trials[$];
        logic [7:0] exp_tr[8];
        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        code_in_v = v.code_in;
        stuck_en  = v.stuck;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(v.exp_data);
        @(negedge clk);
        start   = 1'b0;
        s       = edge_cnt;
        busy_ok = busy;
        n_samp  = sample ? 1 : 0;
        prev_cc = cmp_clk;
        seen    = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            start = (v.glitch && (edge_cnt - s == 10));
            if (cmp_clk && !prev_cc) trials.push_back(dac_code);
            prev_cc = cmp_clk;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (sample) n_samp++;
            end
        end
        start = 1'b0;
        exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("data", {24'd0, data}, {24'd0, exp_d});
            chk("dac_at_done", {24'd0, dac_code}, {24'd0, exp_d});
            chk("err", {31'd0, err}, {31'd0, v.exp_err});
            chk("done_edge", edge_cnt - s, v.exp_lat);
            chk("busy_at_done", {31'd0, busy}, 32'd1);
            chk("busy_throughout", {31'd0, busy_ok}, 32'd1);
            chk("sample_cycles", n_samp, 32'd4);
            if (v.trials) begin
                chk("trial_count", trials.size(), 32'd8);
                for (int i = 0; i < 8 && i < trials.size(); i++)
                    chk("trial_code", {24'd0, trials[i]}, {24'd0, exp_tr[i]});
            end
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_dac", {24'd0, dac_code}, 32'd0);
        if (v.glitch) begin
            repeat (3) @(negedge clk);
            chk("start_while_busy_ignored", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int s;
        int first;
        int second;
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, LAT};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, LAT};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, LAT};
        tbl[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hDF, 1'b1, LAT + STUCK_EXTRA};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, LAT};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {12'd0, cmp_clk, sample, dac_code, data, done, busy, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_conv(tbl[i]);

        // Reset in the middle of a conversion.
        code_in_v = 8'hA5;
        stuck_en  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = edge_cnt;
        for (int k = 0; k < 40 && (edge_cnt - s < 20); k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {12'd0, cmp_clk, sample, dac_code, data, done, busy, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv('{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, LAT});

        // START held high: back-to-back conversions.
        code_in_v = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(8'h5A);
        sb_q.push_back(8'h5A);
        first  = -1;
        second = -1;
        for (int k = 0; k < 400 && second < 0; k++) begin
            @(negedge clk);
            if (done) begin
                chk("held_data", {24'd0, data}, {24'd0, (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX});
                if (first < 0) first = edge_cnt;
                else second = edge_cnt;
            end
        end
        chk("held_period", second - first, PERIOD);
        start = 1'b0;
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        chk("held_returns_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
